// File: rtl/param_regfile.sv
// Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero and ignores its reservations.
module param_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rsv_ok;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok  = we && (waddr != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);
`else
  assign wr_ok  = we;
  assign rsv_ok = rsv_en;
`endif

  // Reservation applied after the write clear: a same-address reserve belongs to a younger instruction.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[waddr] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wr_ok)
        regs[waddr] <= wdata;
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = raddr[g*ADDR_W +: ADDR_W];
    assign hit = wr_ok && (waddr == ra);
    assign rdata[g*DATA_W +: DATA_W] = rst ? '0 : (hit ? wdata : regs[ra]);
    assign rbusy[g] = rst ? 1'b0 : (hit ? 1'b0 : busy[ra]);
  end

endmodule

// File: tb/tb_param_regfile.sv
// Table-driven self-checking bench for param_regfile (default 8-bit, 8-entry, 2-read build).
module tb_param_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [5:0]  raddr;
  logic [15:0] rdata;
  logic [1:0]  rbusy;
  logic [7:0]  busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [7:0] Z77 = 8'h00;
  localparam logic       ZB  = 1'b0;
`else
  localparam logic [7:0] Z77 = 8'h77;
  localparam logic       ZB  = 1'b1;
`endif

  param_regfile #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy), .busy_vec(busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       rb0;
    logic       rb1;
    logic [7:0] bv;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                   input logic r, input logic [2:0] rsa,
                   input logic [2:0] a0, input logic [2:0] a1,
                   input logic [7:0] d0, input logic [7:0] d1,
                   input logic b0, input logic b1, input logic [7:0] bv);
    vecs.push_back('{w, wa, wd, r, rsa, a0, a1, d0, d1, b0, b1, bv});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    raddr = '0;

    // Reads after reset: every address on both ports.
    for (int i = 0; i < 8; i++)
      v(0, 0, 8'h00, 0, 0, 3'(i), 3'(7 - i), 8'h00, 8'h00, 0, 0, 8'h00);
    // Write with bypass, then through storage.
    v(1, 3, 8'hA5, 0, 0, 3, 4, 8'hA5, 8'h00, 0, 0, 8'h00);
    v(0, 0, 8'h00, 0, 0, 3, 3, 8'hA5, 8'hA5, 0, 0, 8'h00);
    // Reserve 5 then write it back.
    v(0, 0, 8'h00, 1, 5, 5, 3, 8'h00, 8'hA5, 0, 0, 8'h00);
    v(0, 0, 8'h00, 0, 0, 5, 5, 8'h00, 8'h00, 1, 1, 8'h20);
    v(1, 5, 8'h3C, 0, 0, 5, 3, 8'h3C, 8'hA5, 0, 0, 8'h20);
    v(0, 0, 8'h00, 0, 0, 5, 5, 8'h3C, 8'h3C, 0, 0, 8'h00);
    // Same-cycle write and reserve to the same address.
    v(0, 0, 8'h00, 1, 2, 2, 2, 8'h00, 8'h00, 0, 0, 8'h00);
    v(1, 2, 8'h11, 1, 2, 2, 5, 8'h11, 8'h3C, 0, 0, 8'h04);
    v(0, 0, 8'h00, 0, 0, 2, 2, 8'h11, 8'h11, 1, 1, 8'h04);
    // Same-cycle write and reserve to different addresses.
    v(1, 7, 8'h5A, 1, 1, 7, 2, 8'h5A, 8'h11, 0, 1, 8'h04);
    v(0, 0, 8'h00, 0, 0, 1, 7, 8'h00, 8'h5A, 1, 0, 8'h06);
    v(1, 2, 8'h22, 0, 0, 2, 1, 8'h22, 8'h00, 0, 1, 8'h06);
    v(0, 0, 8'h00, 0, 0, 2, 1, 8'h22, 8'h00, 0, 1, 8'h02);
    // Register 0 write and reserve.
    v(1, 0, 8'h77, 1, 0, 0, 0, Z77, Z77, 0, 0, 8'h02);
    v(0, 0, 8'h00, 0, 0, 0, 1, Z77, 8'h00, ZB, 1, {7'h01, ZB});
    v(1, 1, 8'h99, 0, 0, 1, 0, 8'h99, Z77, 0, ZB, {7'h01, ZB});
    v(0, 0, 8'h00, 0, 0, 1, 4, 8'h99, 8'h00, 0, 0, {7'h00, ZB});

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_rbusy", 32'(rbusy), 32'h0);
    chk("rst_busy_vec", 32'(busy_vec), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d_rd0", i), 32'(rdata[7:0]),  32'(vecs[i].rd0));
      chk($sformatf("v%0d_rd1", i), 32'(rdata[15:8]), 32'(vecs[i].rd1));
      chk($sformatf("v%0d_rb0", i), 32'(rbusy[0]),    32'(vecs[i].rb0));
      chk($sformatf("v%0d_rb1", i), 32'(rbusy[1]),    32'(vecs[i].rb1));
      chk($sformatf("v%0d_bv", i),  32'(busy_vec),    32'(vecs[i].bv));
      @(posedge clk);
      #1;
    end

    // Reset mid-operation: reserve 1 and 6, write FF to 4, then reset between edges.
    idle_inputs();
    we = 1'b1; waddr = 3'd4; wdata = 8'hFF; rsv_en = 1'b1; rsv_addr = 3'd1;
    @(posedge clk); #1;
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 3'd6;
    @(posedge clk); #1;
    idle_inputs();
    raddr = {3'd6, 3'd4};
    #1;
    chk("mid_pre_rd0", 32'(rdata[7:0]), 32'hFF);
    chk("mid_pre_rb1", 32'(rbusy[1]), 32'h1);
    chk("mid_pre_bv", 32'(busy_vec), 32'({7'h21, ZB}));
    #1;
    rst = 1'b1;
    we = 1'b1; waddr = 3'd4; wdata = 8'hAB;
    #1;
    chk("mid_rst_rd0", 32'(rdata[7:0]), 32'h0);
    chk("mid_rst_rb1", 32'(rbusy[1]), 32'h0);
    chk("mid_rst_bv", 32'(busy_vec), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("mid_post_rd0", 32'(rdata[7:0]), 32'h0);
    chk("mid_post_rb1", 32'(rbusy[1]), 32'h0);
    @(posedge clk); #1;
    chk("mid_edge_rd0", 32'(rdata[7:0]), 32'h0);
    chk("mid_edge_bv", 32'(busy_vec), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
